issue_mul_queue: RTL and testbench
==================================

// Module: issue_mul_queue
// PURPOSE
//  Issue-to-multiplier queue: buffers issue_execute_pack_t entries from the issue stage and presents
//  the oldest entry to execute_mul, which pops it via issue_mul_fifo_pop. One instance per MUL unit.
//  First-word-fall-through FIFO with full backpressure toward issue and a synchronous flush on commit.
// PARAMETERS
//  DEPTH     4   entry count; power of two, >= 2
//  PTR_W     $clog2(DEPTH)   index width (derived, not overridden)
// PORTS
//  clk                            in   1      clock, all state updates on posedge
//  rst                            in   1      synchronous, active-high reset
//  issue_mul_fifo_data_in         in   pack   issue_execute_pack_t written on push
//  issue_mul_fifo_push            in   1      push request from issue
//  issue_mul_fifo_full            out  1      no free entry; push ignored while high
//  issue_mul_fifo_count           out  PTR_W+1  occupied entries, 0..DEPTH
//  issue_mul_fifo_data_out        out  pack   head entry (oldest), combinational from storage
//  issue_mul_fifo_data_out_valid  out  1      head entry present (queue not empty)
//  issue_mul_fifo_pop             in   1      execute_mul consumes head this cycle
//  issue_mul_fifo_flush           in   1      commit_feedback_pack.enable && .flush, registered upstream
// BEHAVIOUR
//  - Storage: DEPTH-entry array; rptr/wptr are PTR_W+1 bits (MSB = wrap bit), both reset to 0.
//  - count = wptr - rptr (mod 2^(PTR_W+1)); empty = (rptr == wptr);
//    full = index bits equal and wrap bits differ.
//  - Reset values: rptr = wptr = 0 -> full = 0, count = 0, data_out_valid = 0, data_out = 'b0.
//    Array contents are not reset.
//  - Accepted push: push && !full. Write data_in at wptr[PTR_W-1:0]; wptr++ at posedge.
//  - Accepted pop: pop && !empty; rptr++ at posedge. Pop while empty is ignored; no underflow.
//  - full blocks push even when a pop occurs the same cycle; no combinational pop->full path.
//    The issue side retries next cycle.
//  - Push + pop same cycle, neither blocked: both pointers advance and count is unchanged.
//  - Push while empty: the entry becomes visible on data_out the next cycle (zero bypass). A same-cycle
//    pop is ignored because valid was 0.
//  - data_out = storage[rptr index] when !empty, else all-zero pack. So data_out.enable = 0 when empty.
//  - data_out_valid = !empty. Pure function of registered pointers; no dependence on pop or push.
//  - Pointer wrap: the index wraps DEPTH-1 -> 0 and toggles the wrap bit. FIFO order is preserved
//    across wrap.
//  - Flush (rst or issue_mul_fifo_flush): rptr = wptr = 0 at posedge. Overrides any same-cycle push
//    and pop; the pushed entry is dropped. The next cycle shows empty, with full = 0.
//  - Reset mid-operation: identical to flush. All in-flight entries are discarded.
//  - Latency: push at cycle N -> data_out_valid at N+1 when the queue was empty.
//    Pop at N -> next entry at N+1.
//  - Pack is passed unmodified: no field is inspected or altered, including sub_op.raw_data.
// TESTING
//  (DEPTH=4, directed, cycle-checked with asserts as in the execute_* difftest benches)
//  1. Reset held 1 cycle, then idle -> valid=0, full=0, count=0, data_out.enable=0.
//  2. Push rob_id 1,2,3,4 on 4 consecutive cycles, pop=0 -> count 1..4; full=1 after 4th.
//     5th push (rob_id 5) ignored. Head rob_id=1.
//  3. From full: pop + push(rob_id 5) same cycle -> push dropped, count=3, head rob_id=2.
//     Next cycle push(5) accepted -> count=4.
//  4. Wrap: push/pop alternating over 10 entries (rob_id 10..19, src1_value=rob_id*3)
//     -> popped order 10..19 exact; count never exceeds 2.
//  5. With 3 entries queued, flush=1 together with push(rob_id 7) and pop=1 -> next cycle
//     count=0, valid=0. A subsequent push(8) appears as head 1 cycle later.
//  6. Empty queue: push(rob_id 9) + pop same cycle -> pop ignored; next cycle valid=1, head rob_id=9,
//     count=1.

Source files
------------

// File: rtl/issue_mul_queue_if.sv
// rtl/issue_mul_queue_if.sv - issue-to-MUL pack type and queue handshake interface
package issue_mul_pkg;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] raw_data;
    } mul_sub_op_t;

    typedef struct packed {
        logic        enable;
        logic [6:0]  rob_id;
        logic [31:0] src1_value;
        logic [31:0] src2_value;
        mul_sub_op_t sub_op;
    } issue_execute_pack_t;

endpackage

interface issue_mul_queue_if #(
    parameter int DEPTH = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    issue_mul_pkg::issue_execute_pack_t issue_mul_fifo_data_in;
    logic                               issue_mul_fifo_push;
    logic                               issue_mul_fifo_full;
    logic [PTR_W:0]                     issue_mul_fifo_count;
    issue_mul_pkg::issue_execute_pack_t issue_mul_fifo_data_out;
    logic                               issue_mul_fifo_data_out_valid;
    logic                               issue_mul_fifo_pop;
    logic                               issue_mul_fifo_flush;

    modport slave (
        input  issue_mul_fifo_data_in,
        input  issue_mul_fifo_push,
        input  issue_mul_fifo_pop,
        input  issue_mul_fifo_flush,
        output issue_mul_fifo_full,
        output issue_mul_fifo_count,
        output issue_mul_fifo_data_out,
        output issue_mul_fifo_data_out_valid
    );

    modport master (
        output issue_mul_fifo_data_in,
        output issue_mul_fifo_push,
        output issue_mul_fifo_pop,
        output issue_mul_fifo_flush,
        input  issue_mul_fifo_full,
        input  issue_mul_fifo_count,
        input  issue_mul_fifo_data_out,
        input  issue_mul_fifo_data_out_valid
    );

endinterface

// File: rtl/issue_mul_queue.sv
// rtl/issue_mul_queue.sv - first-word-fall-through queue between issue and execute_mul
module issue_mul_queue #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    issue_mul_queue_if.slave   q_if
);
    localparam int PTR_W = $clog2(DEPTH);

    issue_mul_pkg::issue_execute_pack_t r_mem [DEPTH];

    logic [PTR_W:0] r_rptr;
    logic [PTR_W:0] r_wptr;

    logic w_empty;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;
    logic w_clear;

    // Wrap bit distinguishes full from empty when the index bits coincide.
    assign w_empty   = (r_rptr == r_wptr);
    assign w_full    = (r_rptr[PTR_W-1:0] == r_wptr[PTR_W-1:0]) &&
                       (r_rptr[PTR_W] != r_wptr[PTR_W]);
    assign w_push_ok = q_if.issue_mul_fifo_push && !w_full;
    assign w_pop_ok  = q_if.issue_mul_fifo_pop && !w_empty;
    assign w_clear   = rst || q_if.issue_mul_fifo_flush;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_rptr <= '0;
            r_wptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Storage is not cleared; entries behind rptr are simply unreachable after a flush.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr[PTR_W-1:0]] <= q_if.issue_mul_fifo_data_in;
        end
    end

    assign q_if.issue_mul_fifo_full           = w_full;
    assign q_if.issue_mul_fifo_count          = r_wptr - r_rptr;
    assign q_if.issue_mul_fifo_data_out_valid = !w_empty;
    assign q_if.issue_mul_fifo_data_out       = w_empty ? '0 : r_mem[r_rptr[PTR_W-1:0]];

endmodule

// File: tb/tb_issue_mul_queue.sv
// tb/tb_issue_mul_queue.sv - scoreboard bench for issue_mul_queue
module tb_issue_mul_queue;
    import issue_mul_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;

    issue_execute_pack_t exp_q [$];

    issue_mul_queue_if #(.DEPTH(4)) q_if ();

    issue_mul_queue #(.DEPTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .q_if (q_if.slave)
    );

    always #5 clk = ~clk;

    function automatic issue_execute_pack_t mk(input int rob);
        issue_execute_pack_t p;
        p.enable           = 1'b1;
        p.rob_id           = rob[6:0];
        p.src1_value       = rob * 3;
        p.src2_value       = ~rob;
        p.sub_op.op        = rob[3:0];
        p.sub_op.raw_data  = 32'hA500_0000 | rob;
        return p;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus; scoreboard learns accepted pushes after the edge commits them.
    task automatic step(input bit push, input int rob, input bit acc,
                        input bit pop, input bit flush, input bit rs);
        q_if.issue_mul_fifo_push    = push;
        q_if.issue_mul_fifo_data_in = mk(rob);
        q_if.issue_mul_fifo_pop     = pop;
        q_if.issue_mul_fifo_flush   = flush;
        rst                         = rs;
        @(posedge clk);
        #1;
        if (flush || rs) exp_q.delete();
        else if (push && acc) exp_q.push_back(mk(rob));
        q_if.issue_mul_fifo_push  = 1'b0;
        q_if.issue_mul_fifo_pop   = 1'b0;
        q_if.issue_mul_fifo_flush = 1'b0;
        rst                       = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && !q_if.issue_mul_fifo_flush) begin
            chk("mon_count", 128'(q_if.issue_mul_fifo_count), 128'(exp_q.size()));
            chk("mon_valid", 128'(q_if.issue_mul_fifo_data_out_valid), 128'(exp_q.size() != 0));
            chk("mon_full", 128'(q_if.issue_mul_fifo_full), 128'(exp_q.size() == 4));
            if (q_if.issue_mul_fifo_data_out_valid && exp_q.size() != 0) begin
                chk("mon_head", 128'(q_if.issue_mul_fifo_data_out), 128'(exp_q[0]));
                if (q_if.issue_mul_fifo_pop) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        q_if.issue_mul_fifo_push    = 1'b0;
        q_if.issue_mul_fifo_pop     = 1'b0;
        q_if.issue_mul_fifo_flush   = 1'b0;
        q_if.issue_mul_fifo_data_in = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset state
        chk("rst_valid", 128'(q_if.issue_mul_fifo_data_out_valid), 128'(0));
        chk("rst_full", 128'(q_if.issue_mul_fifo_full), 128'(0));
        chk("rst_count", 128'(q_if.issue_mul_fifo_count), 128'(0));
        chk("rst_enable", 128'(q_if.issue_mul_fifo_data_out.enable), 128'(0));

        // Fill to full, fifth push dropped
        for (int r = 1; r <= 4; r++) begin
            step(1, r, 1, 0, 0, 0);
            chk("fill_count", 128'(q_if.issue_mul_fifo_count), 128'(r));
        end
        chk("fill_full", 128'(q_if.issue_mul_fifo_full), 128'(1));
        step(1, 5, 0, 0, 0, 0);
        chk("over_count", 128'(q_if.issue_mul_fifo_count), 128'(4));
        chk("over_head", 128'(q_if.issue_mul_fifo_data_out.rob_id), 128'(1));

        // Pop with push while full: push blocked
        step(1, 5, 0, 1, 0, 0);
        chk("pp_full_count", 128'(q_if.issue_mul_fifo_count), 128'(3));
        chk("pp_full_head", 128'(q_if.issue_mul_fifo_data_out.rob_id), 128'(2));
        step(1, 5, 1, 0, 0, 0);
        chk("retry_count", 128'(q_if.issue_mul_fifo_count), 128'(4));

        // Drain 2,3,4,5
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
        chk("drain_count", 128'(q_if.issue_mul_fifo_count), 128'(0));

        // Streaming across pointer wrap
        step(1, 10, 1, 0, 0, 0);
        chk("wrap_head0", 128'(q_if.issue_mul_fifo_data_out.src1_value), 128'(30));
        for (int r = 11; r <= 19; r++) begin
            step(1, r, 1, 1, 0, 0);
            chk("wrap_count", 128'(q_if.issue_mul_fifo_count), 128'(1));
            chk("wrap_head", 128'(q_if.issue_mul_fifo_data_out.src1_value), 128'(r * 3));
        end
        step(0, 0, 0, 1, 0, 0);
        chk("wrap_empty", 128'(q_if.issue_mul_fifo_data_out_valid), 128'(0));

        // Flush beats same-cycle push and pop
        step(1, 20, 1, 0, 0, 0);
        step(1, 21, 1, 0, 0, 0);
        step(1, 22, 1, 0, 0, 0);
        step(1, 7, 0, 1, 1, 0);
        chk("flush_count", 128'(q_if.issue_mul_fifo_count), 128'(0));
        chk("flush_valid", 128'(q_if.issue_mul_fifo_data_out_valid), 128'(0));
        chk("flush_full", 128'(q_if.issue_mul_fifo_full), 128'(0));
        chk("flush_enable", 128'(q_if.issue_mul_fifo_data_out.enable), 128'(0));
        step(1, 8, 1, 0, 0, 0);
        chk("post_flush_head", 128'(q_if.issue_mul_fifo_data_out.rob_id), 128'(8));
        step(0, 0, 0, 1, 0, 0);

        // Push + pop while empty: pop ignored
        step(1, 9, 1, 1, 0, 0);
        chk("empty_pp_valid", 128'(q_if.issue_mul_fifo_data_out_valid), 128'(1));
        chk("empty_pp_head", 128'(q_if.issue_mul_fifo_data_out.rob_id), 128'(9));
        chk("empty_pp_count", 128'(q_if.issue_mul_fifo_count), 128'(1));
        chk("empty_pp_raw", 128'(q_if.issue_mul_fifo_data_out.sub_op.raw_data), 128'(32'hA500_0009));

        // Reset mid-operation
        step(1, 30, 1, 0, 0, 0);
        step(1, 31, 0, 1, 0, 1);
        chk("midrst_count", 128'(q_if.issue_mul_fifo_count), 128'(0));
        chk("midrst_valid", 128'(q_if.issue_mul_fifo_data_out_valid), 128'(0));
        step(0, 0, 0, 0, 0, 0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
